// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample width and the burst-capture state encoding.
// No logic, no latency.
// Imported by adc_interface and the burst capture block so both agree on widths.
package adc_pkg;

    localparam int ADC_DATA_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        ARMED,
        POST,
        READOUT
    } capture_state_t;

endpackage

// File: rtl/burst_sample_ram.sv
// Simple dual-port sample RAM, DEPTH x DATA_W, one write port and one read port.
// Latency: registered read, data appears one clock after rd_en.
// Backpressure: none; rd_dat holds its value while rd_en is low, so a stalled reader sees stable data.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_en/rd_addr read request; rd_dat read data.
module burst_sample_ram #(
    parameter  int DATA_W = 10,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    // No reset on the array or the read register so the tools map both onto EBR.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/adc_burst_capture.sv
// Triggered burst capture: circular pre-trigger history, edge/forced trigger, DEPTH-sample readout.
// Latency: first RD_VALID two clocks after the final post-trigger write, then one sample per clock.
// Backpressure: RD_READY low holds RD_DATA/RD_LAST; input samples are never stalled (dropped in IDLE/READOUT).
// Ports: SYS_CLK/RESET; APP_DATA/APP_DATA_VALID sample stream; ARM/FORCE_TRIG control pulses;
//        CFG_THRESHOLD/CFG_RISING/CFG_PRE latched on ARM; RD_DATA/RD_VALID/RD_READY/RD_LAST burst out;
//        BUSY (not IDLE), TRIGGERED (trigger seen in this capture).
module adc_burst_capture
    import adc_pkg::*;
#(
    parameter  int DATA_W = ADC_DATA_W,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              SYS_CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] APP_DATA,
    input  logic              APP_DATA_VALID,
    input  logic              ARM,
    input  logic              FORCE_TRIG,
    input  logic [DATA_W-1:0] CFG_THRESHOLD,
    input  logic              CFG_RISING,
    input  logic [ADDR_W-1:0] CFG_PRE,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic              RD_LAST,
    output logic              BUSY,
    output logic              TRIGGERED
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);

    capture_state_t    state_q, state_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic              rising_q, rising_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    // PRE_FILL: samples written so far. POST: writes still owed after the trigger sample.
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              force_q, force_d;
    logic              triggered_q, triggered_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   iss_cnt_q, iss_cnt_d;
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;

    logic              edge_hit;
    logic              trig_hit;
    logic              post_done;
    logic              rd_adv;
    logic              rd_hs_last;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rd_dat;

    always_comb begin
        edge_hit = 1'b0;
        if (prev_vld_q) begin
            edge_hit = rising_q ? ((prev_q <  thr_q) && (APP_DATA >= thr_q))
                                : ((prev_q >= thr_q) && (APP_DATA <  thr_q));
        end
    end

    // A FORCE_TRIG pulse coinciding with a valid sample triggers on that very sample.
    assign trig_hit   = (state_q == ARMED) && APP_DATA_VALID && (edge_hit || force_q || FORCE_TRIG);
    assign post_done  = (state_q == POST) && APP_DATA_VALID && (cnt_q == ADDR_W'(1));
    // The output slot can take a new word when it is empty or being drained this cycle.
    assign rd_adv     = !out_vld_q || RD_READY;
    assign rd_hs_last = out_vld_q && RD_READY && out_last_q;

    // State register
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (ARM) state_d = (CFG_PRE == '0) ? ARMED : PRE_FILL;
            PRE_FILL: if (APP_DATA_VALID && (cnt_q == pre_q - ADDR_W'(1))) state_d = ARMED;
            // PRE = DEPTH-1 leaves the trigger sample as the only post sample.
            ARMED:    if (trig_hit) state_d = (pre_q == '1) ? READOUT : POST;
            POST:     if (post_done) state_d = READOUT;
            READOUT:  if (rd_hs_last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs and datapath next-values
    always_comb begin
        thr_d       = thr_q;
        rising_d    = rising_q;
        pre_d       = pre_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        force_d     = 1'b0;
        triggered_d = triggered_q;
        rd_ptr_d    = rd_ptr_q;
        iss_cnt_d   = iss_cnt_q;
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        ram_we      = APP_DATA_VALID &&
                      ((state_q == PRE_FILL) || (state_q == ARMED) || (state_q == POST));
        ram_re      = 1'b0;

        if (ram_we) begin
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            prev_d     = APP_DATA;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ARM) begin
                    thr_d       = CFG_THRESHOLD;
                    rising_d    = CFG_RISING;
                    pre_d       = CFG_PRE;
                    wr_ptr_d    = '0;
                    cnt_d       = '0;
                    prev_vld_d  = 1'b0;
                    triggered_d = 1'b0;
                end
            end
            PRE_FILL: begin
                if (APP_DATA_VALID) cnt_d = cnt_q + ADDR_W'(1);
            end
            ARMED: begin
                // Forced trigger stays pending until the next valid sample consumes it.
                force_d = APP_DATA_VALID ? 1'b0 : (force_q || FORCE_TRIG);
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    // DEPTH-1-PRE writes remain after the trigger sample.
                    cnt_d       = ~pre_q;
                    // Oldest burst sample sits PRE slots behind the trigger address.
                    rd_ptr_d    = wr_ptr_q - pre_q;
                    iss_cnt_d   = '0;
                end
            end
            POST: begin
                if (APP_DATA_VALID) cnt_d = cnt_q - ADDR_W'(1);
            end
            READOUT: begin
                if (rd_adv) begin
                    if (iss_cnt_q != DEPTH_CNT) begin
                        ram_re     = 1'b1;
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                        iss_cnt_d  = iss_cnt_q + (ADDR_W+1)'(1);
                        out_vld_d  = 1'b1;
                        out_last_d = (iss_cnt_q == LAST_CNT);
                    end else begin
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                    end
                end
                if (rd_hs_last) triggered_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            thr_q       <= '0;
            rising_q    <= 1'b0;
            pre_q       <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            force_q     <= 1'b0;
            triggered_q <= 1'b0;
            rd_ptr_q    <= '0;
            iss_cnt_q   <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            thr_q       <= thr_d;
            rising_q    <= rising_d;
            pre_q       <= pre_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            force_q     <= force_d;
            triggered_q <= triggered_d;
            rd_ptr_q    <= rd_ptr_d;
            iss_cnt_q   <= iss_cnt_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
        end
    end

    burst_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (SYS_CLK),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_dat  (APP_DATA),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q),
        .rd_dat  (ram_rd_dat)
    );

    // The RAM output register only advances on a read, so it is stable while stalled.
    assign RD_DATA   = out_vld_q ? ram_rd_dat : '0;
    assign RD_VALID  = out_vld_q;
    assign RD_LAST   = out_vld_q && out_last_q;
    assign BUSY      = (state_q != IDLE);
    assign TRIGGERED = triggered_q;

endmodule

// File: tb/tb_adc_burst_capture.sv
// Directed bench for adc_burst_capture at DEPTH=16: ramp source with a sample every 4th cycle,
// expected burst words queued at ARM and compared at each RD_VALID & RD_READY handshake.
module tb_adc_burst_capture;

    localparam int DW    = 10;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          SYS_CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] APP_DATA;
    logic          APP_DATA_VALID;
    logic          ARM;
    logic          FORCE_TRIG;
    logic [DW-1:0] CFG_THRESHOLD;
    logic          CFG_RISING;
    logic [AW-1:0] CFG_PRE;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          RD_READY;
    logic          RD_LAST;
    logic          BUSY;
    logic          TRIGGERED;

    adc_burst_capture #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .SYS_CLK        (SYS_CLK),
        .RESET          (RESET),
        .APP_DATA       (APP_DATA),
        .APP_DATA_VALID (APP_DATA_VALID),
        .ARM            (ARM),
        .FORCE_TRIG     (FORCE_TRIG),
        .CFG_THRESHOLD  (CFG_THRESHOLD),
        .CFG_RISING     (CFG_RISING),
        .CFG_PRE        (CFG_PRE),
        .RD_DATA        (RD_DATA),
        .RD_VALID       (RD_VALID),
        .RD_READY       (RD_READY),
        .RD_LAST        (RD_LAST),
        .BUSY           (BUSY),
        .TRIGGERED      (TRIGGERED)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ramp_val = '0;
    logic [DW-1:0] const_val = '0;
    logic [DW-1:0] last_sent = '0;
    bit            src_en = 1'b0;
    bit            src_const = 1'b0;
    int            phase = 0;
    int            rd_mode = 0;
    int            rd_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [DW-1:0] start, input bit ramp);
        exp_t e;
        for (int i = 0; i < DEPTH; i++) begin
            e.dat  = ramp ? start + DW'(i) : start;
            e.last = (i == DEPTH - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: score the handshake happening at this edge, then drive the next cycle's inputs.
    task automatic cyc();
        exp_t          e;
        logic          rst_edge;
        logic          stall;
        logic [DW-1:0] held_dat;
        logic          held_last;
        rst_edge = RESET;
        if (!rst_edge && RD_VALID && RD_READY) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_word observed=0x%0h expected=no word", RD_DATA);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(RD_DATA), 32'(e.dat));
                chk("rd_last", 32'(RD_LAST), 32'(e.last));
            end
        end
        stall     = !rst_edge && RD_VALID && !RD_READY;
        held_dat  = RD_DATA;
        held_last = RD_LAST;
        if (!rst_edge && APP_DATA_VALID) last_sent = APP_DATA;
        @(posedge SYS_CLK);
        #1;
        if (stall) begin
            chk("stall_vld", 32'(RD_VALID), 1);
            chk("stall_dat", 32'(RD_DATA), 32'(held_dat));
            chk("stall_last", 32'(RD_LAST), 32'(held_last));
        end
        ARM        = 1'b0;
        FORCE_TRIG = 1'b0;
        RESET      = 1'b0;
        phase      = (phase + 1) % 4;
        APP_DATA_VALID = src_en && (phase == 0);
        APP_DATA   = src_const ? const_val : ramp_val;
        if (APP_DATA_VALID && !src_const) ramp_val = ramp_val + 1'b1;
        RD_READY   = (rd_mode == 0) || (rd_cnt % 3 == 0);
        rd_cnt++;
    endtask

    // ARM with a coincident sample that must not be captured; real data starts 4 cycles later.
    task automatic arm(input logic [DW-1:0] start, input bit is_const);
        src_en         = 1'b1;
        src_const      = is_const;
        const_val      = start;
        ARM            = 1'b1;
        APP_DATA_VALID = 1'b1;
        APP_DATA       = is_const ? start : start - 1'b1;
        ramp_val       = start;
        phase          = 0;
        cyc();
        chk("arm_busy", 32'(BUSY), 1);
    endtask

    task automatic wait_trig(input logic [31:0] exp_sample);
        int n = 0;
        while (!TRIGGERED && n < 2000) begin
            cyc();
            n++;
        end
        chk("trig_seen", 32'(TRIGGERED), 1);
        chk("trig_sample", 32'(last_sent), exp_sample);
    endtask

    task automatic wait_done(input bit arm_in_rd, input int exp_span);
        int n = 0;
        int first = -1;
        bit armed_once = 1'b0;
        while ((BUSY || exp_q.size() != 0) && n < 3000) begin
            if (RD_VALID && first < 0) first = n;
            if (arm_in_rd && !armed_once && RD_VALID) begin
                ARM = 1'b1;
                armed_once = 1'b1;
            end
            cyc();
            n++;
        end
        chk("done_busy", 32'(BUSY), 0);
        chk("done_left", 32'(exp_q.size()), 0);
        chk("done_trig", 32'(TRIGGERED), 0);
        if (exp_span != 0) chk("throughput", 32'(n - first), 32'(exp_span));
        repeat (8) cyc();
        chk("stay_idle", 32'(BUSY), 0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_trig"}, 32'(TRIGGERED), 0);
        chk({tag, "_vld"}, 32'(RD_VALID), 0);
        chk({tag, "_last"}, 32'(RD_LAST), 0);
        chk({tag, "_dat"}, 32'(RD_DATA), 0);
    endtask

    initial begin
        RESET = 1'b1; ARM = 1'b0; FORCE_TRIG = 1'b0; APP_DATA = '0; APP_DATA_VALID = 1'b0;
        CFG_THRESHOLD = '0; CFG_RISING = 1'b1; CFG_PRE = '0; RD_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            RESET = 1'b1;
            cyc();
        end
        chk_cleared("reset");

        // FORCE_TRIG in IDLE does nothing.
        src_en = 1'b1;
        FORCE_TRIG = 1'b1;
        cyc();
        repeat (8) cyc();
        chk("idle_force_trig", 32'(TRIGGERED), 0);
        chk("idle_force_busy", 32'(BUSY), 0);

        // Rising trigger; CFG changes after ARM and ARM pulses in POST/READOUT are ignored.
        CFG_THRESHOLD = 10'h020; CFG_RISING = 1'b1; CFG_PRE = 4'd4;
        arm(10'h000, 1'b0);
        push_burst(10'h01C, 1'b1);
        CFG_THRESHOLD = 10'h3FF; CFG_RISING = 1'b0; CFG_PRE = 4'd9;
        wait_trig('h020);
        ARM = 1'b1;
        cyc();
        wait_done(1'b1, DEPTH);

        // Falling trigger across the 0x3FF -> 0x000 wrap.
        CFG_THRESHOLD = 10'h100; CFG_RISING = 1'b0; CFG_PRE = 4'd8;
        arm(10'h3F0, 1'b0);
        push_burst(10'h3F8, 1'b1);
        wait_trig('h000);
        wait_done(1'b0, DEPTH);

        // Backpressure: RD_READY high one cycle in three.
        rd_mode = 1;
        CFG_THRESHOLD = 10'h020; CFG_RISING = 1'b1; CFG_PRE = 4'd4;
        arm(10'h000, 1'b0);
        push_burst(10'h01C, 1'b1);
        wait_trig('h020);
        wait_done(1'b0, 0);
        // Same again, reset in the middle of a stalled readout.
        arm(10'h000, 1'b0);
        push_burst(10'h01C, 1'b1);
        wait_trig('h020);
        for (int n = 0; n < 500 && !RD_VALID; n++) cyc();
        chk("rd_started", 32'(RD_VALID), 1);
        repeat (3) cyc();
        RESET = 1'b1;
        exp_q.delete();
        cyc();
        chk_cleared("rst_readout");
        rd_mode = 0;

        // PRE=0, constant input, forced trigger 5 cycles after ARM.
        CFG_THRESHOLD = 10'h100; CFG_RISING = 1'b1; CFG_PRE = 4'd0;
        arm(10'h155, 1'b1);
        push_burst(10'h155, 1'b0);
        repeat (4) cyc();
        chk("no_edge_trig", 32'(TRIGGERED), 0);
        FORCE_TRIG = 1'b1;
        cyc();
        wait_trig('h155);
        wait_done(1'b0, DEPTH);

        // Reset mid-POST, then a clean capture.
        CFG_THRESHOLD = 10'h020; CFG_RISING = 1'b1; CFG_PRE = 4'd4;
        arm(10'h000, 1'b0);
        push_burst(10'h01C, 1'b1);
        wait_trig('h020);
        repeat (9) cyc();
        chk("post_busy", 32'(BUSY), 1);
        RESET = 1'b1;
        exp_q.delete();
        cyc();
        chk("rst_post_busy", 32'(BUSY), 0);
        chk("rst_post_trig", 32'(TRIGGERED), 0);
        chk("rst_post_vld", 32'(RD_VALID), 0);
        arm(10'h000, 1'b0);
        push_burst(10'h01C, 1'b1);
        wait_trig('h020);
        wait_done(1'b0, DEPTH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
